// File: rtl/if_fetch.sv
// Instruction-fetch stage: program counter, single-outstanding imem requests,
// stall holding buffer and branch/jump redirect with stale-response draining.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;
  logic [31:0] pc_r, pc_nx_s;
  logic [31:0] instr_buf_r, instr_buf_nx_s;
  logic [31:0] tgt_r, tgt_nx_s;
  logic [31:0] tgt_s;
  logic [31:0] pc_plus4_s;
  logic        req_s;
  logic        valid_s;
  logic [31:0] instr_s;

  assign tgt_s      = {PCTargetE[31:2], 2'b00};
  assign pc_plus4_s = pc_r + 32'd4;

  // State, PC, holding buffer and pending-redirect target registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      instr_buf_r <= NOP;
      tgt_r       <= 32'h0000_0000;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      instr_buf_r <= instr_buf_nx_s;
      tgt_r       <= tgt_nx_s;
    end
  end

  // Next-state and fetch outputs; a redirect always wins over a stall
  always_comb begin
    state_nx_s     = state_r;
    pc_nx_s        = pc_r;
    instr_buf_nx_s = instr_buf_r;
    tgt_nx_s       = tgt_r;
    req_s          = 1'b0;
    valid_s        = 1'b0;
    instr_s        = NOP;
    case (state_r)
      IDLE: begin
        state_nx_s = FETCH;
        if (PCSrcE) begin
          pc_nx_s = tgt_s;
        end else begin
          pc_nx_s = pc_r;
        end
      end
      FETCH: begin
        req_s = 1'b1;
        if (imem_rvalid) begin
          if (PCSrcE) begin
            pc_nx_s = tgt_s;
          end else if (!StallF) begin
            valid_s = 1'b1;
            instr_s = imem_rdata;
            pc_nx_s = pc_plus4_s;
          end else begin
            valid_s        = 1'b1;
            instr_s        = imem_rdata;
            instr_buf_nx_s = imem_rdata;
            state_nx_s     = HOLD;
          end
        end else if (PCSrcE) begin
          // Request is in flight: remember the target, keep the address stable
          tgt_nx_s   = tgt_s;
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = FETCH;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pc_nx_s    = tgt_s;
          state_nx_s = FETCH;
        end else if (!StallF) begin
          valid_s    = 1'b1;
          instr_s    = instr_buf_r;
          pc_nx_s    = pc_plus4_s;
          state_nx_s = FETCH;
        end else begin
          valid_s = 1'b1;
          instr_s = instr_buf_r;
        end
      end
      DRAIN: begin
        req_s = 1'b1;
        if (PCSrcE) begin
          tgt_nx_s = tgt_s;
        end else begin
          tgt_nx_s = tgt_r;
        end
        if (imem_rvalid) begin
          state_nx_s = FETCH;
          if (PCSrcE) begin
            pc_nx_s = tgt_s;
          end else begin
            pc_nx_s = tgt_r;
          end
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_r;
  assign PCF       = pc_r;
  assign PCPlus4F  = pc_plus4_s;
  assign ValidF    = valid_s;
  assign InstrF    = instr_s;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: transaction-level model checked every cycle,
// plus literal expectations pinned at the interesting cycles.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 0;
  int wait_cnt = 0;

  if_fetch dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrF(InstrF),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: responds lat cycles after the request is raised; word = address
  always @(posedge clk) begin
    if (!imem_req || imem_rvalid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign imem_rvalid = imem_req && (wait_cnt >= lat);
  assign imem_rdata  = imem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: started (left reset idle), pc, a held word, and a stale in-flight request
  bit          m_started = 1'b0;
  logic [31:0] m_pc = 32'h0;
  bit          m_buffered = 1'b0;
  logic [31:0] m_bufw = 32'h0;
  bit          m_stale = 1'b0;
  logic [31:0] m_stale_tgt = 32'h0;

  always @(negedge clk) begin
    logic        e_req, e_valid, rv;
    logic [31:0] e_instr, tgt;
    if (!reset) begin
      m_started = 1'b0; m_pc = 32'h0; m_buffered = 1'b0; m_stale = 1'b0;
    end
    e_req   = m_started && !m_buffered;
    rv      = e_req && imem_rvalid;
    e_valid = !PCSrcE && (m_buffered || (rv && !m_stale));
    e_instr = e_valid ? (m_buffered ? m_bufw : imem_rdata) : NOP;
    check("m_req", {31'd0, imem_req}, {31'd0, e_req});
    check("m_valid", {31'd0, ValidF}, {31'd0, e_valid});
    check("m_instr", InstrF, e_instr);
    check("m_pcf", PCF, m_pc);
    check("m_pcplus4", PCPlus4F, m_pc + 32'd4);
    if (e_req) check("m_addr", imem_addr, m_pc);
    if (reset) begin
      tgt = {PCTargetE[31:2], 2'b00};
      if (!m_started) begin
        m_started = 1'b1;
        if (PCSrcE) m_pc = tgt;
      end else if (m_stale) begin
        if (PCSrcE) m_stale_tgt = tgt;
        if (rv) begin m_pc = m_stale_tgt; m_stale = 1'b0; end
      end else if (m_buffered) begin
        if (PCSrcE) begin m_buffered = 1'b0; m_pc = tgt; end
        else if (!StallF) begin m_buffered = 1'b0; m_pc = m_pc + 32'd4; end
      end else if (PCSrcE) begin
        if (rv) m_pc = tgt;
        else begin m_stale = 1'b1; m_stale_tgt = tgt; end
      end else if (rv) begin
        if (!StallF) m_pc = m_pc + 32'd4;
        else begin m_buffered = 1'b1; m_bufw = imem_rdata; end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; lat = 0;
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pcf", PCF, 32'h0);
    check("rst_pcplus4", PCPlus4F, 32'h4);
    check("rst_instr", InstrF, NOP);
    step(); reset = 1'b1;
    @(negedge clk);
    check("idle_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("seq_pcf", PCF, 32'(i * 4));
      check("seq_instr", InstrF, 32'(i * 4));
      check("seq_valid", {31'd0, ValidF}, 32'd1);
    end
    step();
    step(); lat = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_addr", imem_addr, 32'h10);
      check("lat_valid", {31'd0, ValidF}, (i == 2) ? 32'd1 : 32'd0);
    end
    step(); lat = 0; PCSrcE = 1'b1; PCTargetE = 32'h20;
    @(negedge clk);
    check("lat_next_addr", imem_addr, 32'h14);
    check("redir_kill", {31'd0, ValidF}, 32'd0);
    step(); PCSrcE = 1'b0; StallF = 1'b1;
    @(negedge clk);
    check("redir_pen_instr", InstrF, 32'h20);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_instr", InstrF, 32'h20);
    end
    step(); StallF = 1'b0;
    @(negedge clk);
    check("release_valid", {31'd0, ValidF}, 32'd1);
    step(); PCSrcE = 1'b1; PCTargetE = 32'h30;
    @(negedge clk);
    check("release_pcf", PCF, 32'h24);
    step(); lat = 3; PCTargetE = 32'h100;
    @(negedge clk);
    check("drain_addr", imem_addr, 32'h30);
    step(); PCTargetE = 32'h200;
    step(); PCSrcE = 1'b0;
    step();
    @(negedge clk);
    check("stale_valid", {31'd0, ValidF}, 32'd0);
    check("stale_addr", imem_addr, 32'h30);
    step(); lat = 0; StallF = 1'b1;
    @(negedge clk);
    check("drain_target", imem_addr, 32'h200);
    step(); PCSrcE = 1'b1; PCTargetE = 32'h41;
    @(negedge clk);
    check("hold_redir_valid", {31'd0, ValidF}, 32'd0);
    step(); PCSrcE = 1'b0; StallF = 1'b0;
    @(negedge clk);
    check("hold_redir_addr", imem_addr, 32'h40);
    step(); PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step(); PCSrcE = 1'b0;
    @(negedge clk);
    check("wrap_pcf", PCF, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4F, 32'h0);
    step();
    @(negedge clk);
    check("wrap_next", imem_addr, 32'h0);
    step(); lat = 5;
    step();
    @(negedge clk);
    check("wait_req", {31'd0, imem_req}, 32'd1);
    step(); reset = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_pcf", PCF, 32'h0);
    step(); reset = 1'b1; lat = 0;
    repeat (3) @(negedge clk);
    check("post_rst_pcf", PCF, 32'h4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage: owns the program counter, issues single-outstanding requests to the instruction memory, and presents InstrF / PCF / PCPlus4F to the IF/ID pipeline register directly downstream. It absorbs variable memory latency, holds a fetched instruction while the pipeline is stalled, and applies branch/jump redirects from EX, discarding any stale in-flight response.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- NOP, 32'h0000_0013: instruction driven when ValidF=0 (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- StallF  in  1  1 = IF/ID does not load this cycle; the presented instruction must be held.
- PCSrcE  in  1  1 = redirect to PCTargetE this cycle.
- PCTargetE  in  32  redirect target; bits [1:0] are ignored (forced to 0).
- imem_req  out  1  request valid; held high until imem_rvalid.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_rvalid=0.
- imem_rvalid  in  1  response valid; may assert in the same cycle as imem_req (zero-wait).
- imem_rdata  in  32  instruction word, valid when imem_rvalid=1.
- InstrF  out  32  instruction for IF/ID; NOP when ValidF=0.
- PCF  out  32  address of InstrF.
- PCPlus4F  out  32  PCF+4, modulo 2^32.
- ValidF  out  1  InstrF holds a real fetched instruction.

## Operation

- Registers: pc_q (32), state (IDLE/FETCH/HOLD/DRAIN), instr_buf (32), tgt_q (32).
- PCF = pc_q; PCPlus4F = pc_q + 4 with no carry out (0xFFFF_FFFC -> 0x0000_0000); imem_addr = pc_q.
- IDLE (reset state): imem_req=0, ValidF=0. Next edge -> FETCH; if PCSrcE=1, pc_q <= target first.
- FETCH: imem_req=1.
  - imem_rvalid=0, PCSrcE=0: stay.
  - imem_rvalid=0, PCSrcE=1: tgt_q <= target -> DRAIN (request in flight, address must stay stable).
  - imem_rvalid=1: InstrF = imem_rdata (bypass), ValidF=1.
    - PCSrcE=1: response dropped (ValidF forced 0), pc_q <= target, stay FETCH.
    - StallF=0: consumed, pc_q <= pc_q+4, stay FETCH.
    - StallF=1: instr_buf <= imem_rdata -> HOLD.
- HOLD: imem_req=0, InstrF = instr_buf, ValidF=1.
  - PCSrcE=1: buffer dropped (ValidF forced 0 this cycle), pc_q <= target -> FETCH.
  - StallF=0: consumed, pc_q <= pc_q+4 -> FETCH.
  - StallF=1: stay.
- DRAIN: imem_req=1 at the old pc_q, ValidF=0, InstrF=NOP.
  - PCSrcE=1: tgt_q <= new target (latest redirect wins).
  - imem_rvalid=1: response discarded, pc_q <= tgt_q (or the new target if PCSrcE=1 in the same cycle) -> FETCH.
- Priority: PCSrcE over StallF in every state.
- ValidF, InstrF: combinational from state and imem_rvalid. PCSrcE forces ValidF low in the same cycle.

## Timing

- While reset=0: state=IDLE, pc_q=RESET_PC, instr_buf=NOP, tgt_q=0. Outputs: imem_req=0, ValidF=0, InstrF=NOP, PCF=RESET_PC, PCPlus4F=RESET_PC+4.
- Reset asserted mid-request: the request is abandoned at once. The memory must tolerate imem_req dropping without imem_rvalid.
- First imem_req: the second rising edge after reset deasserts (IDLE lasts one cycle).
- Zero-wait memory, no stalls: one instruction per cycle, PCF advancing by 4 each cycle.
- N-cycle memory latency: ValidF=0 for N cycles, then 1 cycle valid if not stalled.
- Redirect penalty: with zero-wait memory, the target instruction appears the cycle after PCSrcE. From DRAIN, it appears at least one cycle after the stale imem_rvalid.
- Never more than one outstanding request.

## Test plan

- Reset then zero-wait memory returning word = address: PCF 0x0,0x4,0x8 on consecutive cycles, InstrF matches, ValidF=1, PCPlus4F=PCF+4.
- 2-cycle memory latency at PC 0x10: imem_req held with imem_addr=0x10 for 3 cycles. ValidF=0,0,1. Next request address is 0x14.
- StallF=1 for 3 cycles while rvalid arrives at 0x20: state HOLD, InstrF stable, imem_req=0. On release, PC goes to 0x24.
- PCSrcE=1 (target 0x100) while waiting on 0x30: stale response discarded, ValidF=0. Next request is 0x100. Second redirect to 0x200 during DRAIN: fetch goes to 0x200.
- PCSrcE=1 and StallF=1 together in HOLD (target 0x41 -> 0x40): buffer dropped, ValidF=0, next imem_addr=0x40.
- Wrap and reset: PC 0xFFFF_FFFC gives PCPlus4F=0x0 and the next fetch at 0x0. Asserting reset mid-wait drops imem_req in the same cycle and sets PCF=RESET_PC.
